// File: rtl/mod_147_3_2_jabber_if.sv
// MII transmit-side signals between the MAC and the jabber monitor.
// The master modport is the MAC side; slave is the monitor.
interface mod_147_3_2_jabber_if;
  logic tx_en;
  logic tx_en_out;
  logic jab;
  logic xmit_max_timer_done;
  logic unjab_timer_done;
  logic xmit_max_timer_not_done;
  logic unjab_timer_not_done;

  modport master (
    output tx_en,
    input  tx_en_out,
    input  jab,
    input  xmit_max_timer_done,
    input  unjab_timer_done,
    input  xmit_max_timer_not_done,
    input  unjab_timer_not_done
  );

  modport slave (
    input  tx_en,
    output tx_en_out,
    output jab,
    output xmit_max_timer_done,
    output unjab_timer_done,
    output xmit_max_timer_not_done,
    output unjab_timer_not_done
  );
endinterface

// File: rtl/mod_147_3_2_jabber.sv
// Clause 147 PCS transmit jabber monitor: gates TX_EN after an over-long frame
// and releases only after a full run of consecutive idle cycles.
module mod_147_3_2_jabber #(
  parameter int unsigned XMIT_MAX_CYCLES = 50000,
  parameter int unsigned UNJAB_CYCLES    = 400000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                   clk,
  input logic                   reset_n,
  mod_147_3_2_jabber_if.slave   mii
);

  typedef enum logic [1:0] {IDLE, XMIT, JAB, UNJAB} state_t;

  localparam logic [CNT_W-1:0] XMIT_LAST  = CNT_W'(XMIT_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNJAB_LAST = CNT_W'(UNJAB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             jab_q;
  logic             xdone_q, xdone_nx;
  logic             udone_q, udone_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      jab_q   <= 1'b0;
      xdone_q <= 1'b0;
      udone_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      jab_q   <= (state_nx == JAB) || (state_nx == UNJAB);
      xdone_q <= xdone_nx;
      udone_q <= udone_nx;
    end
  end

  // The counter is cleared on every transition; the increment guard keeps it
  // saturating even though the terminal compare normally leaves the state first.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    xdone_nx = 1'b0;
    udone_nx = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (mii.tx_en) begin
          state_nx = XMIT;
          cnt_nx   = CNT_ONE;
        end
      end
      XMIT: begin
        if (!mii.tx_en) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == XMIT_LAST) begin
          state_nx = JAB;
          cnt_nx   = '0;
          xdone_nx = 1'b1;
        end else if (cnt != '1) begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      JAB: begin
        cnt_nx = '0;
        if (!mii.tx_en) begin
          state_nx = UNJAB;
          cnt_nx   = CNT_ONE;
        end
      end
      UNJAB: begin
        if (mii.tx_en) begin
          state_nx = JAB;
          cnt_nx   = '0;
        end else if (cnt == UNJAB_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          udone_nx = 1'b1;
        end else if (cnt != '1) begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign mii.jab                     = jab_q;
  assign mii.tx_en_out               = mii.tx_en & ~jab_q;
  assign mii.xmit_max_timer_done     = xdone_q;
  assign mii.unjab_timer_done        = udone_q;
  assign mii.xmit_max_timer_not_done = (state == XMIT);
  assign mii.unjab_timer_not_done    = (state == JAB) || (state == UNJAB);

endmodule

// File: doc/mod_147_3_2_jabber.md
# mod_147_3_2_jabber

Synthesizable transmit jabber monitor for the Clause 147 PCS transmit path. It sits between the MII transmit interface and the PCS transmit state machine and consumes its own cycle-counted xmit_max and unjab timers. When a transmission runs longer than the xmit_max limit, it asserts jab and masks TX_EN toward the PCS. It releases only after TX_EN has stayed low for the full unjab period.

## Interface
Parameters:
- XMIT_MAX_CYCLES, default 50000: 2.0 ms at the 25 MHz MII clock; maximum allowed consecutive tx_en-high cycles. Legal range 2..2^20-1.
- UNJAB_CYCLES, default 400000: 16.0 ms at 25 MHz; consecutive tx_en-low cycles required to leave jab. Legal range 2..2^20-1.
- CNT_W, default 20: width of the shared cycle counter. Must hold max(XMIT_MAX_CYCLES, UNJAB_CYCLES).

Ports:
- clk  in  1  MII transmit clock (25 MHz); single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- tx_en  in  1  MII TX_EN from the MAC.
- tx_en_out  out  1  gated TX_EN to the PCS transmit function.
- jab  out  1  jabber active; registered.
- xmit_max_timer_done  out  1  one-cycle pulse when the xmit_max limit is hit.
- unjab_timer_done  out  1  one-cycle pulse when unjab completes.
- xmit_max_timer_not_done  out  1  high while the xmit_max count is running (state XMIT).
- unjab_timer_not_done  out  1  high while in states JAB or UNJAB.

## Operation
- There are four states: IDLE, XMIT, JAB, UNJAB.
- One shared counter, cnt (CNT_W bits), serves both timers. It is cleared on every state transition and never wraps; it saturates at its terminal value.
- **IDLE**, cnt = 0:
  - tx_en = 1 → XMIT, with cnt = 1.
- **XMIT**:
  - tx_en = 0 → IDLE.
  - tx_en = 1 and cnt = XMIT_MAX_CYCLES-1 → JAB, with jab = 1 and a one-cycle xmit_max_timer_done pulse.
  - Otherwise cnt increments.
- **JAB**:
  - tx_en = 1 → stay in JAB, cnt held at 0.
  - tx_en = 0 → UNJAB, with cnt = 1.
- **UNJAB**:
  - tx_en = 1 → JAB, and the count restarts. The unjab period requires consecutive low cycles.
  - tx_en = 0 and cnt = UNJAB_CYCLES-1 → IDLE, with jab = 0 and a one-cycle unjab_timer_done pulse.
  - Otherwise cnt increments.
- Output equations:
  - tx_en_out = tx_en & ~jab, combinational from the registered jab.
  - A frame already in progress is truncated the cycle after jab rises.
- Done pulses are registered and high for exactly one clk cycle. They are never asserted simultaneously.

## Timing
- Reset values (asynchronous; on any reset_n low, including mid-frame or mid-unjab):
  - state = IDLE, cnt = 0, jab = 0.
  - Both done pulses = 0; both not_done outputs = 0.
  - tx_en_out follows tx_en.
- Reset release: the first rising edge with reset_n high samples normally.
- Jab threshold:
  - tx_en high for N consecutive sampled cycles with N < XMIT_MAX_CYCLES: no jab.
  - N = XMIT_MAX_CYCLES: jab is 1 after the edge sampling the XMIT_MAX_CYCLES-th high cycle, and tx_en_out is 0 from that point.
  - A frame that ends exactly on the (XMIT_MAX_CYCLES-1)-th cycle returns to IDLE with no jab.
- tx_en falling and rising on back-to-back cycles in XMIT: passes through IDLE for one cycle, and the count restarts from 1.
- Unjab release: jab deasserts on the edge sampling the UNJAB_CYCLES-th consecutive low cycle. tx_en_out may follow tx_en from the next cycle.
- tx_en high in the same cycle the unjab count would complete: the transition to JAB wins over release.
- Latency of jab and the done pulses relative to the sampled tx_en: 1 clk. tx_en_out has no added latency.

## Test plan
Simulation overrides: XMIT_MAX_CYCLES = 10, UNJAB_CYCLES = 20.

- **Short frame.** Reset, then tx_en high for 9 cycles, then low → jab stays 0 throughout, tx_en_out mirrors tx_en, and no done pulse occurs.
- **Jab entry.** tx_en high for 15 cycles → xmit_max_timer_done pulses once after the 10th high sample. jab = 1 from then on, and tx_en_out = 0 for cycles 11–15.
- **Clean unjab.** After jab entry, tx_en low for 20 cycles → unjab_timer_done pulses once on the 20th low sample and jab returns to 0. A following 5-cycle frame passes ungated.
- **Interrupted unjab.** After jab entry, tx_en low for 12 cycles, high for 1 cycle, then low for 20 cycles → jab stays 1 until the 20th low cycle of the second run. The unjab pulse occurs exactly once.
- **Reset mid-operation.** Assert reset_n low during XMIT at cnt = 7 and again during UNJAB at cnt = 15 → all outputs return immediately to their reset values. A new 9-cycle frame after release does not jab.
- **Back-to-back frames.** 9 cycles high, 1 cycle low, 9 cycles high → no jab, confirming the counter clears in IDLE.
